// File: rtl/mmu_sched.sv
// Tile scheduler for the systolic matrix-multiply unit: sequences weight load,
// compute and writeback per tile, with abort and a sub-controller watchdog.
module mmu_sched #(
   parameter int width_height = 16,
   parameter int addr_width   = 8,
   parameter int tile_width   = 8,
   parameter int timeout      = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [tile_width-1:0] num_tiles,
   input  logic [addr_width-1:0] wt_base,
   input  logic [addr_width-1:0] in_base,
   input  logic [addr_width-1:0] out_base,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [tile_width-1:0] tile_idx,
   output logic                  wt_active,
   output logic [addr_width-1:0] wt_addr,
   input  logic                  wt_done,
   output logic                  rd_active,
   output logic [addr_width-1:0] in_addr,
   output logic [addr_width-1:0] out_addr,
   input  logic                  wr_done
);

   localparam int wd_width = $clog2(timeout + 1);
   localparam logic [addr_width-1:0] stride   = addr_width'(width_height);
   localparam logic [wd_width-1:0]   wd_limit = wd_width'(timeout);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      WAIT_W,
      COMPUTE,
      WAIT_C,
      NEXT,
      DONE,
      ERR
   } state_t;

   state_t                state;
   logic [tile_width-1:0] count;
   logic [wd_width-1:0]   wdog;
   logic                  last_tile;

   // Widened compare so a full-scale tile count cannot wrap the +1.
   always_comb begin
      last_tile = (({1'b0, tile_idx} + (tile_width + 1)'(1)) == {1'b0, count});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         wdog      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tile_idx  <= '0;
         wt_active <= 1'b0;
         rd_active <= 1'b0;
         wt_addr   <= '0;
         in_addr   <= '0;
         out_addr  <= '0;
      end else begin
         wt_active <= 1'b0;
         rd_active <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (start) begin
                  count    <= num_tiles;
                  wt_addr  <= wt_base;
                  in_addr  <= in_base;
                  out_addr <= out_base;
                  tile_idx <= '0;
                  err      <= 1'b0;
                  if (num_tiles == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= LOAD_W;
                     wt_active <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
            end

            LOAD_W: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wdog  <= '0;
                  state <= WAIT_W;
               end
            end

            // Completion beats timeout; abort beats both.
            WAIT_W: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (wt_done) begin
                  state     <= COMPUTE;
                  rd_active <= 1'b1;
               end else if (wdog == wd_limit) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end

            COMPUTE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  wdog  <= '0;
                  state <= WAIT_C;
               end
            end

            WAIT_C: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (wr_done) begin
                  state <= NEXT;
               end else if (wdog == wd_limit) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end

            NEXT: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (last_tile) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  tile_idx  <= tile_idx + 1'b1;
                  wt_addr   <= wt_addr + stride;
                  in_addr   <= in_addr + stride;
                  out_addr  <= out_addr + stride;
                  state     <= LOAD_W;
                  wt_active <= 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mmu_sched.md
# mmu_sched

Tile scheduler for the systolic matrix-multiply unit. Accepts a host job of N tiles and, for each tile, sequences a weight load, then an input-read/compute pass through the read controller, then waits for output writeback before advancing memory base addresses. Sits between the host command interface and the weight-load, read (`rd_control`) and output-write controllers. Includes a start/busy/done handshake, abort, and a watchdog that flags a stalled sub-controller.

## Interface
- `width_height`, 16: array dimension; rows per tile and per-tile address stride.
- `addr_width`, 8: width of every base address.
- `tile_width`, 8: width of tile count and index.
- `timeout`, 1024: max wait cycles for `wt_done`/`wr_done` before error; must be at least 1.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request, sampled in IDLE/ERR only.
- `abort`  in  1  cancel current job.
- `num_tiles`  in  tile_width  tile count, latched on accepted start.
- `wt_base`, `in_base`, `out_base`  in  addr_width each  job base addresses, latched on accepted start.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle job-complete pulse.
- `err`  out  1  sticky watchdog error.
- `tile_idx`  out  tile_width  current tile index.
- `wt_active`  out  1  one-cycle weight-load trigger.
- `wt_addr`  out  addr_width  weight base for current tile.
- `wt_done`  in  1  weight load complete pulse.
- `rd_active`  out  1  one-cycle trigger to read controller.
- `in_addr`, `out_addr`  out  addr_width each  input and output bases for current tile.
- `wr_done`  in  1  output writeback complete pulse.

## Operation
- States: IDLE, LOAD_W, WAIT_W, COMPUTE, WAIT_C, NEXT, DONE, ERR. All outputs are registered or decoded from the state register only; no input-to-output combinational path.
- IDLE: when `start`=1, latch `num_tiles` and the three bases into `wt_addr`/`in_addr`/`out_addr`, and clear `tile_idx`. Go to DONE if `num_tiles`=0, else to LOAD_W.
- LOAD_W: `wt_active`=1 for this cycle. Clear watchdog. Go to WAIT_W.
- WAIT_W: on `wt_done`, go to COMPUTE. Otherwise increment watchdog; when it equals `timeout`, go to ERR.
- COMPUTE: `rd_active`=1 for this cycle. Clear watchdog. Go to WAIT_C.
- WAIT_C: same as WAIT_W, using `wr_done`, and advance to NEXT.
- NEXT: if `tile_idx`+1 equals the latched count, go to DONE. Otherwise increment `tile_idx`, add `width_height` to all three addresses modulo 2^addr_width, and go to LOAD_W.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `err`=1. An accepted `start` clears `err` and behaves as in IDLE.
- `busy`=1 in LOAD_W, WAIT_W, COMPUTE, WAIT_C and NEXT; 0 elsewhere.
- `abort` in any busy state goes to IDLE next cycle with no `done` pulse. It is ignored in IDLE, DONE and ERR. `abort` has priority over `wt_done`/`wr_done`/timeout in the same cycle.
- `start` is ignored while busy or in DONE.
- `wt_done`/`wr_done` outside their wait state are ignored and not remembered.
- A done pulse has priority over timeout in the same cycle.
- Addresses and `tile_idx` hold their values in IDLE/DONE/ERR and after abort.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE. `busy`, `done`, `err`, `wt_active`, `rd_active` = 0; `tile_idx` and all addresses = 0.
- `start` sampled at edge k: `busy` and `wt_active` high in cycle k+1.
- `wt_done` sampled at edge j: `rd_active` high in cycle j+1.
- `wr_done` at edge m: NEXT in cycle m+1. Then either `done` in m+2, or `wt_active` for the next tile in m+2 with the advanced addresses already valid.
- Per-tile overhead: 4 controller cycles plus sub-controller latencies.
- Zero-tile job: `done` in cycle k+1, `busy` never asserted.
- Watchdog: with no done, `err` rises `timeout`+1 cycles after the wait state is entered.
- Reset asserted mid-job: immediate return to reset values, with no `done`.

## Test plan
- Reset then idle: all outputs 0; `wt_done`/`wr_done` pulses cause no state change.
- num_tiles=3, bases 0x10/0x40/0x80, sub-controllers answering after 5 cycles: `wt_active`/`rd_active` each pulse 3 times. `wt_addr` takes 0x10, 0x20, 0x30; `out_addr` takes 0x80, 0x90, 0xA0. Exactly one `done` pulse; `busy` falls the cycle `done` rises.
- num_tiles=0: `done` the cycle after `start`; no triggers; `busy` stays 0.
- Wrap-around: `in_base`=0xF8, num_tiles=2 → `in_addr` takes 0xF8 then 0x08.
- Watchdog: `timeout`=8, `wr_done` never arrives → `err`=1 after 9 WAIT_C cycles and stays set. A new `start` clears it and runs the job normally.
- `abort` the same cycle as `wt_done` in WAIT_W: IDLE next cycle, no `rd_active`, no `done`. `start` during a busy job is ignored (latched count unchanged).
